// File: rtl/opll_bus_capture.sv
// OPLL register-write bus capture: synchronizes the asynchronous CPU bus,
// pairs address/data writes into events and queues them in a show-ahead
// FIFO together with the cycle delta since the previous event.
module opll_bus_capture #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DELTA_W     = 16
) (
  input  logic                          i_XIN_EMUCLK,
  input  logic                          i_IC_n,
  input  logic                          i_CS_n,
  input  logic                          i_WR_n,
  input  logic                          i_A0,
  input  logic [7:0]                    i_D,
  input  logic                          i_READY,
  output logic                          o_VALID,
  output logic [7:0]                    o_ADDR,
  output logic [7:0]                    o_DATA,
  output logic [DELTA_W-1:0]            o_DELTA,
  output logic [$clog2(FIFO_DEPTH):0]   o_COUNT,
  output logic                          o_OVF,
  output logic                          o_ORPHAN
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = 16 + DELTA_W;
  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_HAVE_ADDR = 1'b1;

  // synchronizer chains; the last stage is the only copy used downstream
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] a0_sync;
  logic [7:0]             d_sync [SYNC_STAGES];

  // strobe edge detection
  logic [FILL_W-1:0] fill_q;
  logic              pipe_live_c;
  logic              strobe_act_c;
  logic              prev_act_q;
  logic              detect_c;
  logic              wr_stb_q;
  logic              wr_a0_q;
  logic [7:0]        wr_d_q;

  // pairing FSM
  logic [0:0] state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic       push_c;
  logic       orphan_c;

  // FIFO and counters
  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [DELTA_W-1:0] delta_q;
  logic               ovf_q;
  logic               orphan_q;
  logic               valid_c;
  logic               full_c;
  logic               pop_c;
  logic               push_ok_c;
  logic [ENT_W-1:0]   head_c;

  // bus input synchronizers, held at idle bus values in reset
  always_ff @(posedge i_XIN_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      cs_sync <= '1;
      wr_sync <= '1;
      a0_sync <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) d_sync[i] <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_CS_n};
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], i_WR_n};
      a0_sync   <= {a0_sync[SYNC_STAGES-2:0], i_A0};
      d_sync[0] <= i_D;
      for (int i = 1; i < int'(SYNC_STAGES); i++) d_sync[i] <= d_sync[i-1];
    end
  end

  // the chain only reflects real pin samples once it has refilled after reset;
  // until then the previous-strobe flag is forced active so a strobe already
  // held at reset release never looks like a fresh falling edge
  assign pipe_live_c  = (fill_q == FILL_W'(SYNC_STAGES));
  assign strobe_act_c = ~cs_sync[SYNC_STAGES-1] & ~wr_sync[SYNC_STAGES-1];
  assign detect_c     = pipe_live_c & strobe_act_c & ~prev_act_q;

  // one registered write event per strobe, with A0/D captured at detection
  always_ff @(posedge i_XIN_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      fill_q     <= '0;
      prev_act_q <= 1'b1;
      wr_stb_q   <= 1'b0;
      wr_a0_q    <= 1'b0;
      wr_d_q     <= '0;
    end else begin
      if (!pipe_live_c) fill_q <= fill_q + FILL_W'(1);
      prev_act_q <= pipe_live_c ? strobe_act_c : 1'b1;
      wr_stb_q   <= detect_c;
      if (detect_c) begin
        wr_a0_q <= a0_sync[SYNC_STAGES-1];
        wr_d_q  <= d_sync[SYNC_STAGES-1];
      end
    end
  end

  // pairing FSM state and address latch
  always_ff @(posedge i_XIN_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // address writes (re)load the latch; data writes push only with an address held
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    push_c   = 1'b0;
    orphan_c = 1'b0;
    if (wr_stb_q) begin
      if (!wr_a0_q) begin
        addr_d  = wr_d_q;
        state_d = ST_HAVE_ADDR;
      end else if (state_q == ST_HAVE_ADDR) begin
        push_c = 1'b1;
      end else begin
        orphan_c = 1'b1;
      end
    end
  end

  assign valid_c   = (count_q != '0);
  assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_c     = valid_c & i_READY;
  assign push_ok_c = push_c & (~full_c | pop_c);

  // FIFO pointers, occupancy, sticky flags and the inter-event delta counter
  always_ff @(posedge i_XIN_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      delta_q  <= '0;
      ovf_q    <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok_c && !pop_c)      count_q <= count_q + CNT_W'(1);
      else if (!push_ok_c && pop_c) count_q <= count_q - CNT_W'(1);
      if (push_c && !push_ok_c) ovf_q    <= 1'b1;
      if (orphan_c)             orphan_q <= 1'b1;
      if (push_c)                delta_q <= DELTA_W'(1);
      else if (delta_q != '1)    delta_q <= delta_q + DELTA_W'(1);
    end
  end

  // event storage; contents are qualified by occupancy so no reset is needed
  always_ff @(posedge i_XIN_EMUCLK) begin
    if (push_ok_c) mem[wr_ptr_q] <= {addr_q, wr_d_q, delta_q};
  end

  assign head_c   = valid_c ? mem[rd_ptr_q] : '0;
  assign o_VALID  = valid_c;
  assign o_ADDR   = head_c[ENT_W-1 -: 8];
  assign o_DATA   = head_c[DELTA_W +: 8];
  assign o_DELTA  = head_c[DELTA_W-1:0];
  assign o_COUNT  = count_q;
  assign o_OVF    = ovf_q;
  assign o_ORPHAN = orphan_q;

endmodule

// File: tb/tb_opll_bus_capture.sv
// Bench for opll_bus_capture: directed scenarios plus a randomized write
// stream, checked against a queue-based event model.
module tb_opll_bus_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        a0 = 1'b0;
  logic [7:0]  d = 8'h00;
  logic        ready = 1'b0;
  logic        o_valid;
  logic [7:0]  o_addr;
  logic [7:0]  o_data;
  logic [15:0] o_delta;
  logic [4:0]  o_count;
  logic        o_ovf;
  logic        o_orphan;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // reference model: bus pairing state, sticky flags, expected FIFO contents
  bit            m_have;
  logic [7:0]    m_addr;
  bit            m_orphan;
  bit            m_ovf;
  int            origin;
  logic [31:0]   exp_q[$];

  opll_bus_capture #(.FIFO_DEPTH(16), .SYNC_STAGES(2), .DELTA_W(16)) dut (
    .i_XIN_EMUCLK(clk),
    .i_IC_n(rst_n),
    .i_CS_n(cs_n),
    .i_WR_n(wr_n),
    .i_A0(a0),
    .i_D(d),
    .i_READY(ready),
    .o_VALID(o_valid),
    .o_ADDR(o_addr),
    .o_DATA(o_data),
    .o_DELTA(o_delta),
    .o_COUNT(o_count),
    .o_OVF(o_ovf),
    .o_ORPHAN(o_orphan)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // every accepted pop is compared against the head of the model queue
  always begin
    @(negedge clk);
    #2;
    if (rst_n && o_valid && ready) begin
      check("head_present", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("head", {o_addr, o_data, o_delta}, exp_q.pop_front());
    end
  end

  // mode 0: plain write; 1: pop exactly on the push cycle; 2: check push latency
  task automatic bus_write(input bit wa0, input logic [7:0] wd, input int mode);
    int p;
    int dl;
    @(negedge clk);
    a0 = wa0; d = wd; cs_n = 1'b0; wr_n = 1'b0;
    // first sampling edge is cyc+1; the event lands three edges later
    p = cyc + 4;
    if (!wa0) begin
      m_have = 1'b1;
      m_addr = wd;
    end else if (!m_have) begin
      m_orphan = 1'b1;
    end else begin
      dl = p - origin;
      if (dl > 65535) dl = 65535;
      origin = p;
      if (exp_q.size() < 16 || mode == 1) exp_q.push_back({m_addr, wd, 16'(dl)});
      else m_ovf = 1'b1;
    end
    repeat (3) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    if (mode == 1) begin
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      repeat (2) @(negedge clk);
    end else if (mode == 2) begin
      #1 check("lat_before", 32'(o_valid), 32'd0);
      @(negedge clk);
      #1 check("lat_at", 32'(o_valid), 32'd1);
      repeat (2) @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic model_clear();
    m_have = 1'b0; m_addr = 8'h00; m_orphan = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ready = 1'b0;
    cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; d = 8'h00;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    origin = cyc + 1;
  endtask

  task automatic drain(input string tag);
    int n;
    ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    @(negedge clk);
    ready = 1'b0;
    #1;
    check({tag, "_model_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_count"}, 32'(o_count), 32'd0);
    check({tag, "_head_zero"}, {o_addr, o_data, o_delta}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    origin = 1;
    // reset state while held
    #12;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_flags", {30'd0, o_ovf, o_orphan}, 32'd0);

    // single event after 100 idle cycles, with push latency check
    do_reset();
    repeat (100) @(negedge clk);
    bus_write(1'b0, 8'h10, 0);
    bus_write(1'b1, 8'h61, 2);
    #1;
    check("s1_count", 32'(o_count), 32'd1);
    check("s1_orphan", 32'(o_orphan), 32'd0);
    check("s1_event", {o_addr, o_data, o_delta}, exp_q[0]);
    drain("s1");

    // data write with no address
    do_reset();
    bus_write(1'b1, 8'h20, 0);
    #1;
    check("s2_valid", 32'(o_valid), 32'd0);
    check("s2_orphan", 32'(o_orphan), 32'(m_orphan));

    // repeated data writes reuse the latched address, consumed live
    do_reset();
    ready = 1'b1;
    bus_write(1'b0, 8'h30, 0);
    bus_write(1'b1, 8'h11, 0);
    bus_write(1'b1, 8'h22, 0);
    drain("s3");

    // overflow: 17 pairs into a 16-deep FIFO
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus_write(1'b0, 8'(8'h40 + i), 0);
      bus_write(1'b1, 8'(8'h80 + 3 * i), 0);
    end
    #1;
    check("s4_count", 32'(o_count), 32'd16);
    check("s4_ovf", 32'(o_ovf), 32'(m_ovf));
    check("s4_ovf_set", 32'(o_ovf), 32'd1);
    drain("s4");

    // full FIFO with a pop on the push cycle accepts the event
    do_reset();
    bus_write(1'b0, 8'h55, 0);
    for (int i = 0; i < 16; i++) bus_write(1'b1, 8'(i), 0);
    #1 check("s5_full", 32'(o_count), 32'd16);
    bus_write(1'b1, 8'hAB, 1);
    #1;
    check("s5_count", 32'(o_count), 32'd16);
    check("s5_ovf", 32'(o_ovf), 32'd0);
    drain("s5");

    // randomized write stream against the model
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus_write(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 8'($urandom), 0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      #1;
      check("rnd_orphan", 32'(o_orphan), 32'(m_orphan));
      check("rnd_ovf", 32'(o_ovf), 32'(m_ovf));
    end
    drain("rnd");

    // asynchronous reset mid-FIFO, strobe held across release, delta saturation
    do_reset();
    bus_write(1'b0, 8'h66, 0);
    for (int i = 0; i < 3; i++) bus_write(1'b1, 8'(8'hC0 + i), 0);
    #1 check("s6_pre_count", 32'(o_count), 32'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; d = 8'h99;
    #1;
    check("s6_rst_valid", 32'(o_valid), 32'd0);
    check("s6_rst_count", 32'(o_count), 32'd0);
    check("s6_rst_head", {o_addr, o_data, o_delta}, 32'd0);
    check("s6_rst_flags", {30'd0, o_ovf, o_orphan}, 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    origin = cyc + 1;
    repeat (5) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("s6_held_valid", 32'(o_valid), 32'd0);
    check("s6_held_orphan", 32'(o_orphan), 32'd0);
    bus_write(1'b1, 8'h05, 0);
    #1;
    check("s6_orphan", 32'(o_orphan), 32'(m_orphan));
    check("s6_orphan_set", 32'(o_orphan), 32'd1);
    check("s6_no_event", 32'(o_valid), 32'd0);
    repeat (66000) @(negedge clk);
    bus_write(1'b0, 8'h7E, 0);
    bus_write(1'b1, 8'h3C, 0);
    #1;
    check("s6_sat_delta", 32'(o_delta), 32'hFFFF);
    check("s6_sat_event", {o_addr, o_data, o_delta}, exp_q[0]);
    drain("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
